// File: rtl/exhaustive_pattern_capture_pkg.sv
// Shared types and MISR step for the exhaustive pattern capture slice.
// Used by the RTL and by the bench reference model.
package trojan_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          SIG_W_DEF     = 16;
  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

  function automatic logic [15:0] misr_next(
    input logic [15:0] sig,
    input logic        b,
    input logic [15:0] poly
  );
    return {sig[14:0], 1'b0}
         ^ (sig[15] ? poly : 16'h0000)
         ^ {15'h0000, b};
  endfunction

endpackage

// File: rtl/exhaustive_pattern_capture_if.sv
// Stimulus, response and result handshake bundle between the capture
// stage (master) and the DUT model / result consumer (slave).
interface exhaustive_pattern_capture_if #(
  parameter int N_IN  = 4,
  parameter int SIG_W = 16
);
  logic                 start;
  logic [0:N_IN-1]      pattern;
  logic                 pattern_valid;
  logic                 dut_out;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [2**N_IN-1:0]   rsp_bitmap;
  logic [SIG_W-1:0]     signature;

  modport master (
    input  start,
    input  dut_out,
    input  res_ready,
    output pattern,
    output pattern_valid,
    output busy,
    output res_valid,
    output rsp_bitmap,
    output signature
  );

  modport slave (
    output start,
    output dut_out,
    output res_ready,
    input  pattern,
    input  pattern_valid,
    input  busy,
    input  res_valid,
    input  rsp_bitmap,
    input  signature
  );
endinterface

// File: rtl/exhaustive_pattern_capture_misr.sv
// Serial-input MISR: shift left, fold the polynomial on the
// outgoing MSB, and xor the response bit into the LSB.
module misr_compactor #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             CK,
  input  logic             clear,
  input  logic             enable,
  input  logic             data,
  output logic [SIG_W-1:0] signature
);

  always_ff @(posedge CK) begin
    if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-1){1'b0}}, data};
    end
  end

endmodule

// File: rtl/exhaustive_pattern_capture.sv
// Sweeps every N_IN-bit input pattern in ascending order, samples the
// DUT response after a settle window, and returns bitmap + signature.
module exhaustive_pattern_capture
  import trojan_capture_pkg::*;
#(
  parameter int               N_IN      = 4,
  parameter int               SETTLE    = 1,
  parameter int               SIG_W     = SIG_W_DEF,
  parameter logic [SIG_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic                        CK,
  input  logic                        reset,
  exhaustive_pattern_capture_if.master bus
);

  localparam int              NPAT     = 2**N_IN;
  localparam logic [N_IN-1:0] LAST     = '1;
  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);

  state_t          state;
  logic [N_IN-1:0] pat;
  logic [7:0]      cnt;
  logic [NPAT-1:0] bitmap;
  logic [SIG_W-1:0] sig;
  logic            accept;
  logic            sample;

  assign accept = (state == IDLE) && bus.start;
  assign sample = (state == RUN) && (cnt == SETTLE_C);

  always_ff @(posedge CK) begin
    if (reset) begin
      state  <= IDLE;
      pat    <= '0;
      cnt    <= '0;
      bitmap <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            pat    <= '0;
            cnt    <= '0;
            bitmap <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            bitmap[pat] <= bus.dut_out;
            cnt         <= '0;
            if (pat == LAST) state <= DONE;
            else             pat   <= pat + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  misr_compactor #(
    .SIG_W (SIG_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .CK        (CK),
    .clear     (reset | accept),
    .enable    (sample),
    .data      (bus.dut_out),
    .signature (sig)
  );

  assign bus.pattern       = pat;
  assign bus.pattern_valid = (state == RUN);
  assign bus.busy          = (state != IDLE);
  assign bus.res_valid     = (state == DONE);
  assign bus.rsp_bitmap    = bitmap;
  assign bus.signature     = sig;

endmodule

// File: tb/tb_exhaustive_pattern_capture.sv
// Randomized scoreboard bench for exhaustive_pattern_capture.
// Two instances: SETTLE=1 (main) and SETTLE=3 (latency scaling).
module tb_exhaustive_pattern_capture;
  import trojan_capture_pkg::*;

  typedef struct {
    logic [15:0] bm;
    logic [15:0] sig;
    int          lat;
  } exp_t;

  logic CK = 1'b0;
  logic reset;
  always #5 CK = ~CK;

  exhaustive_pattern_capture_if #(.N_IN(4), .SIG_W(16)) bus_a ();
  exhaustive_pattern_capture_if #(.N_IN(4), .SIG_W(16)) bus_b ();

  exhaustive_pattern_capture #(.N_IN(4), .SETTLE(1)) dut_a (
    .CK    (CK),
    .reset (reset),
    .bus   (bus_a)
  );

  exhaustive_pattern_capture #(.N_IN(4), .SETTLE(3)) dut_b (
    .CK    (CK),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [15:0] truth_a = 16'h0;
  logic [15:0] truth_b = 16'h0;
  logic        and_a   = 1'b0;

  assign bus_a.dut_out = and_a ? &bus_a.pattern
                               : truth_a[bus_a.pattern];
  assign bus_b.dut_out = truth_b[bus_b.pattern];

  exp_t q[$];
  int   vec     = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   t_start = -1;
  logic rv_q    = 1'b0;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] t,
                                 input logic andm, input int settle);
    exp_t e;
    logic r;
    logic [3:0] p;
    e.bm  = '0;
    e.sig = '0;
    for (int i = 0; i < 16; i++) begin
      p = 4'(i);
      r = andm ? (p == 4'hF) : t[i];
      e.bm[i] = r;
      e.sig   = misr_next(e.sig, r, 16'h1021);
    end
    e.lat = 16 * (settle + 1);
    return e;
  endfunction

  // scoreboard monitor: pattern timing while running, result on res_valid rise
  always @(negedge CK) begin
    exp_t e;
    if (bus_a.pattern_valid && t_start >= 0)
      chk("pattern", 32'(bus_a.pattern), 32'((cyc - t_start) / 2));
    if (bus_a.res_valid && !rv_q) begin
      if (q.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL unexpected_result: got res_valid expected none");
      end else begin
        e = q.pop_front();
        chk("bitmap", bus_a.rsp_bitmap, e.bm);
        chk("signature", bus_a.signature, e.sig);
        chk("latency", 32'(cyc - t_start), 32'(e.lat));
      end
    end
    rv_q = bus_a.res_valid;
  end

  task automatic sweep_a(input logic [15:0] t, input logic andm,
                         input int hold, input int restart_at);
    exp_t e;
    int   n;
    truth_a = t;
    and_a   = andm;
    e       = model(t, andm, 1);
    q.push_back(e);
    t_start     = cyc + 1;
    bus_a.start = 1'b1;
    @(negedge CK);
    bus_a.start = 1'b0;
    if (restart_at >= 0) begin
      n = 0;
      while (32'(bus_a.pattern) != 32'(restart_at) && n < 100) begin
        @(negedge CK);
        n++;
      end
      bus_a.start = 1'b1;
      @(negedge CK);
      bus_a.start = 1'b0;
    end
    n = 0;
    while (!bus_a.res_valid && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (!bus_a.res_valid) begin
      vec++;
      bad++;
      $display("FAIL timeout: got no res_valid expected within 200");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus_a.start = i[0];
      @(negedge CK);
      chk("hold_valid", bus_a.res_valid, 1);
      chk("hold_busy", bus_a.busy, 1);
      chk("hold_bitmap", bus_a.rsp_bitmap, e.bm);
      chk("hold_sig", bus_a.signature, e.sig);
      chk("hold_pattern", 32'(bus_a.pattern), 15);
    end
    bus_a.start     = 1'b1;
    bus_a.res_ready = 1'b1;
    @(negedge CK);
    bus_a.start     = 1'b0;
    bus_a.res_ready = 1'b0;
    chk("ack_busy", bus_a.busy, 0);
    chk("ack_valid", bus_a.res_valid, 0);
    chk("ack_bitmap", bus_a.rsp_bitmap, e.bm);
    chk("ack_sig", bus_a.signature, e.sig);
    @(negedge CK);
    chk("idle_busy", bus_a.busy, 0);
    t_start = -1;
  endtask

  initial begin
    exp_t eb;
    int   n;
    int   b_start;
    reset           = 1'b1;
    bus_a.start     = 1'b0;
    bus_a.res_ready = 1'b0;
    bus_b.start     = 1'b0;
    bus_b.res_ready = 1'b0;
    repeat (3) @(negedge CK);
    reset = 1'b0;
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_valid", bus_a.res_valid, 0);
    chk("rst_pv", bus_a.pattern_valid, 0);
    chk("rst_pattern", 32'(bus_a.pattern), 0);
    chk("rst_bitmap", bus_a.rsp_bitmap, 0);
    chk("rst_sig", bus_a.signature, 0);
    chk("rst_b_busy", bus_b.busy, 0);
    repeat (2) @(negedge CK);

    sweep_a(16'h0000, 1'b0, 0, -1);
    sweep_a(16'h0000, 1'b1, 0, -1);
    chk("and_sig_const", bus_a.signature, 16'h0001);
    sweep_a(16'hFFFF, 1'b0, 0, -1);
    chk("ones_sig_const", bus_a.signature, 16'hFFFF);
    sweep_a(16'($urandom), 1'b0, 5, -1);

    // abort mid-sweep with reset at pattern 7
    truth_a = 16'($urandom);
    and_a   = 1'b0;
    q.push_back(model(truth_a, 1'b0, 1));
    t_start     = cyc + 1;
    bus_a.start = 1'b1;
    @(negedge CK);
    bus_a.start = 1'b0;
    n = 0;
    while (32'(bus_a.pattern) != 7 && n < 100) begin
      @(negedge CK);
      n++;
    end
    chk("reach_p7", 32'(bus_a.pattern), 7);
    reset   = 1'b1;
    t_start = -1;
    void'(q.pop_back());
    @(negedge CK);
    reset = 1'b0;
    chk("abort_busy", bus_a.busy, 0);
    chk("abort_pattern", 32'(bus_a.pattern), 0);
    chk("abort_pv", bus_a.pattern_valid, 0);
    chk("abort_bitmap", bus_a.rsp_bitmap, 0);
    chk("abort_sig", bus_a.signature, 0);
    chk("abort_valid", bus_a.res_valid, 0);
    @(negedge CK);
    sweep_a(16'h0000, 1'b0, 0, -1);

    sweep_a(16'($urandom), 1'b0, 2, 3);
    for (int k = 0; k < 6; k++)
      sweep_a(16'($urandom), 1'b0, int'($urandom_range(0, 4)), -1);

    // SETTLE=3 instance, all-ones response
    truth_b     = 16'hFFFF;
    eb          = model(truth_b, 1'b0, 3);
    b_start     = cyc + 1;
    bus_b.start = 1'b1;
    @(negedge CK);
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.res_valid && n < 300) begin
      @(negedge CK);
      n++;
    end
    chk("b_latency", 32'(cyc - b_start), 32'(eb.lat));
    chk("b_latency_const", 32'(cyc - b_start), 64);
    chk("b_bitmap", bus_b.rsp_bitmap, eb.bm);
    chk("b_sig", bus_b.signature, eb.sig);
    bus_b.res_ready = 1'b1;
    @(negedge CK);
    bus_b.res_ready = 1'b0;
    chk("b_idle", bus_b.busy, 0);

    repeat (3) @(negedge CK);
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/exhaustive_pattern_capture.md
Name: exhaustive_pattern_capture

Overview:
Synthesizable stimulus/response stage that sits around a small trojan-detection test DUT. It drives every input pattern of an N_IN-bit combinational/sequential DUT in ascending binary order and samples the DUT's single-bit output after a settle window. It packs the responses into a bitmap and compacts them into a MISR signature. It presents the result to a downstream logger/comparator over a valid/ready handshake, replacing file-based capture for on-chip golden-vs-suspect comparison.

Parameters:
N_IN, 4, DUT input width; the pattern space is 2**N_IN.
SETTLE, 1, extra cycles each pattern is held before sampling; legal range 1..255.
SIG_W, 16, MISR signature width.
MISR_POLY, 16'h1021, MISR feedback polynomial, SIG_W bits wide.

Ports:
CK  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
pattern  output  [0:N_IN-1]  DUT stimulus; pattern[0] is the MSB.
pattern_valid  output  1  high while pattern is being driven (RUN).
dut_out  input  1  DUT response (output_single).
busy  output  1  high in RUN and DONE.
res_valid  output  1  result available (DONE).
res_ready  input  1  consumer accepts the result.
rsp_bitmap  output  2**N_IN  bit i = response sampled for pattern value i.
signature  output  SIG_W  MISR value over all responses, pattern 0 first.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): state=IDLE; pattern=0, pattern_valid=0, busy=0, res_valid=0, rsp_bitmap=0, signature=0, settle counter=0.
- Reset asserted mid-sweep or in DONE aborts with no result; the outputs above apply from the cycle after the reset edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> RUN, pattern=0, cnt=0, rsp_bitmap=0, signature=0.
  - start=0 -> remain in IDLE.
- RUN: pattern_valid=1.
  - Each edge with cnt<SETTLE: cnt++.
  - At the edge with cnt==SETTLE:
    - rsp_bitmap[pattern]<=dut_out.
    - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? MISR_POLY : 0) ^ {{SIG_W-1{0}},dut_out}.
    - cnt<=0.
    - If pattern==2**N_IN-1 -> DONE; otherwise pattern++.
  - Each pattern is held for exactly SETTLE+1 cycles.
- Latency: res_valid rises exactly 2**N_IN*(SETTLE+1) edges after the start-accept edge. Defaults give 32 cycles.
- DONE:
  - res_valid=1; pattern_valid=0; pattern holds 2**N_IN-1.
  - rsp_bitmap and signature are stable.
  - res_valid=1 && res_ready=1 at an edge -> IDLE. rsp_bitmap and signature keep their values until the next accepted start.
  - res_ready low: hold indefinitely (backpressure). No timeout.
- start is ignored while busy; it is not queued.
- start and res_ready high in the same DONE cycle: handshake completes and the FSM goes to IDLE; start is ignored. A new start is needed in IDLE.
- res_ready is ignored outside DONE.
- dut_out is sampled only on sample edges; its value at any other time has no effect.
- No wrap-around past the last pattern. The pattern counter is N_IN bits; the terminal compare prevents overflow.

Decomposition:
- Shared package trojan_capture_pkg:
  - state enum {IDLE,RUN,DONE}.
  - Default MISR_POLY constant.
  - Function misr_next(sig, bit, poly), shared with the bench reference model.
- One sub-module, misr_compactor: SIG_W/MISR_POLY parameters; clear, enable and data inputs; signature output.
- The FSM, counters and bitmap stay in the top module.

Test Plan:
1. Defaults, dut_out tied 0, single start pulse -> pattern sweeps 0..15, each held 2 cycles; res_valid rises 32 edges after start; rsp_bitmap=16'h0000; signature=16'h0000.
2. dut_out = AND of all pattern bits (model DUT) -> rsp_bitmap=16'h8000; signature equals the misr_next reference over 15 zeros then a one.
3. dut_out tied 1 -> rsp_bitmap=16'hFFFF; signature matches the package-function model. Repeat with SETTLE=3 -> res_valid at 64 cycles, same bitmap and signature.
4. Backpressure: res_ready held low 5 cycles in DONE -> res_valid and outputs stable, extra start pulses ignored. res_ready=1 -> IDLE next edge, busy=0.
5. Reset asserted while pattern=7 -> next cycle busy=0, pattern=0, pattern_valid=0, rsp_bitmap=0. A subsequent start produces a full sweep identical to scenario 1.
6. start pulsed during RUN at pattern=3 -> no restart; the sweep continues to 15 with unchanged latency.
